riscv_inst_msg_disasm: RTL and testbench
========================================

# riscv_inst_msg_disasm

Registered disassembler for 32-bit RISC-V (RV32IM) instruction messages. Each cycle it decodes the instruction word and produces a fixed-width, space-padded ASCII string suitable for line tracing and test reports. It sits beside the processor fetch/decode path as a debug/trace aid and never affects datapath state.

## Interface
- No parameters.
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- msg  input  32  instruction word (standard RISC-V bit layout: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25])
- dasm  output  192  24 ASCII chars; char 0 in bits [191:184], char 23 in [7:0]

## Operation
- Field extraction is pure slicing of msg:
  - I immediate = msg[31:20].
  - S immediate = {msg[31:25], msg[11:7]}.
  - SB offset = {msg[31], msg[7], msg[30:25], msg[11:8], 0}, 13 bits.
  - U immediate = msg[31:12].
  - UJ offset = {msg[31], msg[19:12], msg[20], msg[30:21], 0}, 21 bits.
- Mnemonic is lowercase, in chars 0-5, left-justified and space-padded. Char 6 is a space.
- The operand text starts at char 7. All unused trailing chars are 0x20.
- Register token: "r" plus two decimal digits (r00-r31).
- Immediate token: "0x" plus lowercase hex, zero-extended to the digit count listed below. Immediates are shown raw, not sign-extended.
- Formats (digit counts):
  - R (0110011): "MN rd, rs1, rs2".
    - funct7 0000000: add sll slt sltu xor srl or and.
    - funct7 0100000: sub (f3 000), sra (f3 101).
    - funct7 0000001: mul mulh mulhsu mulhu div divu rem remu.
  - I-arith (0010011): "MN rd, rs1, 0xHHH" for addi slti sltiu xori ori andi.
    - Shifts slli/srli/srai use "0xHH", shamt = msg[24:20].
    - srai is f3 101 with msg[30]=1.
  - jalr (1100111): I format, "0xHHH".
  - Loads (0000011): "MN rd, 0xHHH(rs1)" for lb lh lw lbu lhu.
  - Stores (0100011): "MN rs2, 0xHHH(rs1)" for sb sh sw.
  - Branches (1100011): "MN rs1, rs2, 0xHHHH" for beq bne blt bge bltu bgeu.
  - lui (0110111) / auipc (0010111): "MN rd, 0xHHHHH".
  - jal (1101111): "MN rd, 0xHHHHHH".
- Any unlisted opcode, funct3 or funct7 combination gives "???" followed by 21 spaces.
- Separators are exactly ", " between operands. There is no trailing comma.

## Timing
- One-cycle latency: dasm registers the disassembly of the msg value sampled at each rising edge.
- When reset is high at an edge, dasm becomes 24 spaces (all bytes 0x20). Reset takes priority over msg.
- Reset asserted mid-stream clears dasm on that edge. The first edge after deassertion shows the current msg.
- No handshake. Every edge updates dasm.
- X/Z on msg is not required to be decoded.

## Test plan
- Reset: hold reset for 2 cycles with msg=0x00300233 -> dasm is 24 spaces. Release reset -> after 1 edge, "add    r04, r00, r03".
- R-type: msg=0x409F8A33 -> "sub    r20, r31, r09" one cycle later. Then a MUL with rs1=7 -> "mul" mnemonic.
- I-type: msg=0x8AD98793 -> "addi   r15, r19, 0x8ad". Also cover srai with shamt 0x10.
- S-type: msg=0xFE062FA3 -> "sw     r00, 0xfff(r12)".
- U/UJ-type:
  - msg=0xDEADB8B7 -> "lui    r17, 0xdeadb".
  - jal with offset 0x04dfca, rd=0 -> "jal    r00, 0x04dfca".
- Illegal and back-to-back:
  - msg=0x00000000 -> "???" plus spaces.
  - Alternate two instructions on consecutive cycles -> each string appears exactly one cycle after its msg.

Source files
------------

// File: rtl/riscv_inst_msg_disasm.sv
// RV32IM instruction disassembler for line tracing.
// Each clock edge registers a 24-char, space-padded ASCII rendering of msg.
module riscv_inst_msg_disasm (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  msg,
  output logic [191:0] dasm
);

  typedef enum logic [3:0] {
    FMT_ILL, FMT_R, FMT_I, FMT_SH, FMT_LD, FMT_ST, FMT_BR, FMT_U, FMT_J
  } fmt_e;

  // Top bit of each character slot that an operand token can start on.
  localparam int C7  = 135;
  localparam int C10 = 111;
  localparam int C12 = 95;
  localparam int C14 = 79;
  localparam int C15 = 71;
  localparam int C17 = 55;
  localparam int C18 = 47;
  localparam int C19 = 39;
  localparam int C21 = 23;

  localparam logic [15:0] SEP = 16'h2c20;
  localparam logic [15:0] HEX_PFX = 16'h3078;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [11:0] imm_i, imm_s;
  logic [12:0] off_b;
  logic [19:0] imm_u;
  logic [20:0] off_j;
  logic [47:0] h_i, h_s, h_sh, h_b, h_u, h_j;
  logic [47:0] mn;
  fmt_e        fmt;
  logic [191:0] text;

  function automatic logic [7:0] hex_ch(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  function automatic logic [47:0] hex6(input logic [23:0] v);
    return {hex_ch(v[23:20]), hex_ch(v[19:16]), hex_ch(v[15:12]),
            hex_ch(v[11:8]),  hex_ch(v[7:4]),   hex_ch(v[3:0])};
  endfunction

  function automatic logic [23:0] reg_tok(input logic [4:0] r);
    logic [7:0] tens;
    logic [7:0] ones;
    if (r >= 5'd30) begin
      tens = 8'h33; ones = 8'h30 + {3'b000, r} - 8'd30;
    end else if (r >= 5'd20) begin
      tens = 8'h32; ones = 8'h30 + {3'b000, r} - 8'd20;
    end else if (r >= 5'd10) begin
      tens = 8'h31; ones = 8'h30 + {3'b000, r} - 8'd10;
    end else begin
      tens = 8'h30; ones = 8'h30 + {3'b000, r};
    end
    return {8'h72, tens, ones};
  endfunction

  assign opcode = msg[6:0];
  assign rd     = msg[11:7];
  assign f3     = msg[14:12];
  assign rs1    = msg[19:15];
  assign rs2    = msg[24:20];
  assign f7     = msg[31:25];
  assign imm_i  = msg[31:20];
  assign imm_s  = {msg[31:25], msg[11:7]};
  assign off_b  = {msg[31], msg[7], msg[30:25], msg[11:8], 1'b0};
  assign imm_u  = msg[31:12];
  assign off_j  = {msg[31], msg[19:12], msg[20], msg[30:21], 1'b0};

  assign h_i  = hex6({12'h000, imm_i});
  assign h_s  = hex6({12'h000, imm_s});
  assign h_sh = hex6({19'h00000, rs2});
  assign h_b  = hex6({11'h000, off_b});
  assign h_u  = hex6({4'h0, imm_u});
  assign h_j  = hex6({3'b000, off_j});

  // Pick the mnemonic and operand layout; anything unrecognised stays "???".
  always_comb begin
    mn  = "???   ";
    fmt = FMT_ILL;
    unique case (opcode)
      7'b0110011: begin
        fmt = FMT_R;
        if (f7 == 7'b0000000) begin
          unique case (f3)
            3'b000: mn = "add   ";
            3'b001: mn = "sll   ";
            3'b010: mn = "slt   ";
            3'b011: mn = "sltu  ";
            3'b100: mn = "xor   ";
            3'b101: mn = "srl   ";
            3'b110: mn = "or    ";
            3'b111: mn = "and   ";
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          mn = "sub   ";
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          mn = "sra   ";
        end else if (f7 == 7'b0000001) begin
          unique case (f3)
            3'b000: mn = "mul   ";
            3'b001: mn = "mulh  ";
            3'b010: mn = "mulhsu";
            3'b011: mn = "mulhu ";
            3'b100: mn = "div   ";
            3'b101: mn = "divu  ";
            3'b110: mn = "rem   ";
            3'b111: mn = "remu  ";
          endcase
        end else begin
          fmt = FMT_ILL;
        end
      end
      7'b0010011: begin
        fmt = FMT_I;
        unique case (f3)
          3'b000: mn = "addi  ";
          3'b010: mn = "slti  ";
          3'b011: mn = "sltiu ";
          3'b100: mn = "xori  ";
          3'b110: mn = "ori   ";
          3'b111: mn = "andi  ";
          3'b001: begin mn = "slli  "; fmt = FMT_SH; end
          3'b101: begin mn = msg[30] ? "srai  " : "srli  "; fmt = FMT_SH; end
        endcase
      end
      7'b1100111: begin
        if (f3 == 3'b000) begin mn = "jalr  "; fmt = FMT_I; end
      end
      7'b0000011: begin
        fmt = FMT_LD;
        unique case (f3)
          3'b000: mn = "lb    ";
          3'b001: mn = "lh    ";
          3'b010: mn = "lw    ";
          3'b100: mn = "lbu   ";
          3'b101: mn = "lhu   ";
          default: fmt = FMT_ILL;
        endcase
      end
      7'b0100011: begin
        fmt = FMT_ST;
        unique case (f3)
          3'b000: mn = "sb    ";
          3'b001: mn = "sh    ";
          3'b010: mn = "sw    ";
          default: fmt = FMT_ILL;
        endcase
      end
      7'b1100011: begin
        fmt = FMT_BR;
        unique case (f3)
          3'b000: mn = "beq   ";
          3'b001: mn = "bne   ";
          3'b100: mn = "blt   ";
          3'b101: mn = "bge   ";
          3'b110: mn = "bltu  ";
          3'b111: mn = "bgeu  ";
          default: fmt = FMT_ILL;
        endcase
      end
      7'b0110111: begin mn = "lui   "; fmt = FMT_U; end
      7'b0010111: begin mn = "auipc "; fmt = FMT_U; end
      7'b1101111: begin mn = "jal   "; fmt = FMT_J; end
      default: ;
    endcase
  end

  // Every register token is three chars wide, so each format has fixed slots.
  always_comb begin
    text = {24{8'h20}};
    text[191 -: 48] = mn;
    unique case (fmt)
      FMT_R: begin
        text[C7 -: 24] = reg_tok(rd);   text[C10 -: 16] = SEP;
        text[C12 -: 24] = reg_tok(rs1); text[C15 -: 16] = SEP;
        text[C17 -: 24] = reg_tok(rs2);
      end
      FMT_I, FMT_SH: begin
        text[C7 -: 24] = reg_tok(rd);   text[C10 -: 16] = SEP;
        text[C12 -: 24] = reg_tok(rs1); text[C15 -: 16] = SEP;
        text[C17 -: 16] = HEX_PFX;
        if (fmt == FMT_SH) text[C19 -: 16] = h_sh[15:0];
        else               text[C19 -: 24] = h_i[23:0];
      end
      FMT_LD, FMT_ST: begin
        text[C7 -: 24]  = reg_tok((fmt == FMT_ST) ? rs2 : rd);
        text[C10 -: 16] = SEP;
        text[C12 -: 16] = HEX_PFX;
        text[C14 -: 24] = (fmt == FMT_ST) ? h_s[23:0] : h_i[23:0];
        text[C17 -: 8]  = 8'h28;
        text[C18 -: 24] = reg_tok(rs1);
        text[C21 -: 8]  = 8'h29;
      end
      FMT_BR: begin
        text[C7 -: 24] = reg_tok(rs1);  text[C10 -: 16] = SEP;
        text[C12 -: 24] = reg_tok(rs2); text[C15 -: 16] = SEP;
        text[C17 -: 16] = HEX_PFX;      text[C19 -: 32] = h_b[31:0];
      end
      FMT_U, FMT_J: begin
        text[C7 -: 24] = reg_tok(rd);   text[C10 -: 16] = SEP;
        text[C12 -: 16] = HEX_PFX;
        if (fmt == FMT_J) text[C14 -: 48] = h_j;
        else              text[C14 -: 40] = h_u[39:0];
      end
      default: ;
    endcase
  end

  // Reset blanks the trace line; otherwise it follows msg with one edge of delay.
  always_ff @(posedge clk) begin
    if (reset) dasm <= {24{8'h20}};
    else       dasm <= text;
  end

endmodule

// File: tb/tb_riscv_inst_msg_disasm.sv
// Scoreboard bench for riscv_inst_msg_disasm: the driver queues expected
// strings at each negedge, the monitor pops one just after each posedge.
module tb_riscv_inst_msg_disasm;

  logic         clk;
  logic         reset;
  logic [31:0]  msg;
  logic [191:0] dasm;

  typedef struct {
    logic [191:0] exp;
    string        tag;
  } sb_t;

  sb_t sbq[$];
  int  total = 0;
  int  bad   = 0;

  localparam logic [191:0] SPACES = {24{8'h20}};

  riscv_inst_msg_disasm dut (
    .clk   (clk),
    .reset (reset),
    .msg   (msg),
    .dasm  (dasm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [191:0] pad24(input string s);
    logic [191:0] r;
    r = SPACES;
    for (int i = 0; i < s.len() && i < 24; i++) r[191 - 8*i -: 8] = s[i];
    return r;
  endfunction

  function automatic logic [31:0] r_enc(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] b_enc(input logic [12:0] off, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] j_enc(input logic [20:0] off, input logic [4:0] rd);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
  endfunction

  task automatic checkOutput(input string tag, input logic [191:0] actual,
                             input logic [191:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got '%s' (%h) want '%s'", tag, actual, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [31:0] m,
                               input string text, input string tag);
    sb_t e;
    @(negedge clk);
    reset = r;
    msg   = m;
    e.exp = r ? SPACES : pad24(text);
    e.tag = tag;
    sbq.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      sb_t e;
      e = sbq.pop_front();
      checkOutput(e.tag, dasm, e.exp);
    end
  end

  initial begin
    reset = 1'b1;
    msg   = 32'h0;

    applyStimulus(1'b1, 32'h00300233, "", "reset0");
    applyStimulus(1'b1, 32'h00300233, "", "reset1");
    applyStimulus(1'b0, 32'h00300233, "add    r04, r00, r03", "add");
    applyStimulus(1'b0, 32'h409F8A33, "sub    r20, r31, r09", "sub");
    applyStimulus(1'b0, r_enc(7'b0000001, 5'd2, 5'd7, 3'b000, 5'd5, 7'b0110011),
                  "mul    r05, r07, r02", "mul");
    applyStimulus(1'b0, r_enc(7'b0000001, 5'd29, 5'd8, 3'b111, 5'd11, 7'b0110011),
                  "remu   r11, r08, r29", "remu");
    applyStimulus(1'b0, 32'h8AD98793, "addi   r15, r19, 0x8ad", "addi");
    applyStimulus(1'b0, r_enc(7'b0100000, 5'h10, 5'd4, 3'b101, 5'd3, 7'b0010011),
                  "srai   r03, r04, 0x10", "srai");
    applyStimulus(1'b0, r_enc(7'b0000000, 5'h1f, 5'd2, 3'b001, 5'd2, 7'b0010011),
                  "slli   r02, r02, 0x1f", "slli");
    applyStimulus(1'b0, {12'h004, 5'd5, 3'b000, 5'd1, 7'b1100111},
                  "jalr   r01, r05, 0x004", "jalr");
    applyStimulus(1'b0, {12'h7f0, 5'd2, 3'b010, 5'd10, 7'b0000011},
                  "lw     r10, 0x7f0(r02)", "lw");
    applyStimulus(1'b0, 32'hFE062FA3, "sw     r00, 0xfff(r12)", "sw");
    applyStimulus(1'b0, b_enc(13'h0a64, 5'd30, 5'd1, 3'b001),
                  "bne    r01, r30, 0x0a64", "bne");
    applyStimulus(1'b0, 32'hDEADB8B7, "lui    r17, 0xdeadb", "lui");
    applyStimulus(1'b0, {20'h00012, 5'd31, 7'b0010111}, "auipc  r31, 0x00012", "auipc");
    applyStimulus(1'b0, j_enc(21'h04dfca, 5'd0), "jal    r00, 0x04dfca", "jal");
    applyStimulus(1'b0, 32'h00000000, "???", "illegal_op");
    applyStimulus(1'b0, r_enc(7'b0100000, 5'd1, 5'd1, 3'b001, 5'd1, 7'b0110011),
                  "???", "illegal_f7");

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h409F8A33, "sub    r20, r31, r09", "b2b_sub");
      applyStimulus(1'b0, 32'h8AD98793, "addi   r15, r19, 0x8ad", "b2b_addi");
    end

    applyStimulus(1'b1, 32'h409F8A33, "", "mid_reset");
    applyStimulus(1'b0, 32'hFE062FA3, "sw     r00, 0xfff(r12)", "post_reset");

    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(posedge clk);
    #2;
    checkOutput("drain", 192'(sbq.size()), 192'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
